load_store_unit: RTL



---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Converts byte-addressed RV32I load/store requests from the core into
//   word accesses on a word-addressed data memory with a combinational read.
//   Sub-word stores are a read-modify-write pair of cycles. Misaligned
//   accesses and illegal funct3 values end in an error response and
//   never touch memory.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready only in IDLE)
//   req_write           1 = store, 0 = load
//   req_funct3          RV32I width/sign code
//   req_addr            byte address
//   req_wdata           store data (low byte/half for SB/SH)
//   resp_valid          one-cycle completion pulse
//   resp_rdata          extended load data; 0 for stores and errors
//   resp_err            misaligned/illegal request, qualified by resp_valid
//   mem_write_enable    memory write strobe
//   mem_address         memory word index
//   mem_data_in         memory write data
//   mem_data_out        memory read data (same-cycle)
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_merge;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_accept;
  logic                  w_bad_funct3;
  logic                  w_misaligned;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_accept = req_valid && (r_state == IDLE);

  // Stores only know B/H/W; loads additionally have BU/HU.
  always_comb begin
    w_bad_funct3 = 1'b1;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_bad_funct3 = 1'b0;
      3'b100, 3'b101:         w_bad_funct3 = req_write;
      default:                w_bad_funct3 = 1'b1;
    endcase
  end

  // funct3[1:0] encodes the access size for every legal code.
  assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

  // Lane selection for loads from the same-cycle memory read.
  always_comb begin
    w_byte = 8'h00;
    case (r_addr[1:0])
      2'd0: w_byte = mem_data_out[7:0];
      2'd1: w_byte = mem_data_out[15:8];
      2'd2: w_byte = mem_data_out[23:16];
      2'd3: w_byte = mem_data_out[31:24];
      default: w_byte = 8'h00;
    endcase
  end

  assign w_half = r_addr[1] ? mem_data_out[31:16] : mem_data_out[15:0];

  always_comb begin
    w_load_data = mem_data_out;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h000000, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0000, w_half};
      default: w_load_data = mem_data_out;
    endcase
  end

  // Replace the addressed byte/half lane of the previously read word.
  always_comb begin
    w_merged = r_merge;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_addr[1:0])
        2'd0: w_merged[7:0]   = r_wdata[7:0];
        2'd1: w_merged[15:8]  = r_wdata[7:0];
        2'd2: w_merged[23:16] = r_wdata[7:0];
        2'd3: w_merged[31:24] = r_wdata[7:0];
        default: w_merged = r_merge;
      endcase
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (w_bad_funct3 || w_misaligned) begin
              r_rdata <= '0;
              r_state <= ERR;
            end else if (!req_write) begin
              r_state <= LOAD;
            end else if (req_funct3 == 3'b010) begin
              r_state <= WRITE;
            end else begin
              r_state <= READ;
            end
          end
        end
        LOAD: begin
          r_rdata <= w_load_data;
          r_state <= RESP;
        end
        READ: begin
          r_merge <= mem_data_out;
          r_state <= WRITE;
        end
        WRITE: begin
          r_rdata <= '0;
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registered state only, so an asynchronous
  // reset drops the write strobe immediately.
  assign req_ready        = (r_state == IDLE);
  assign resp_valid       = (r_state == RESP) || (r_state == ERR);
  assign resp_err         = (r_state == ERR);
  assign resp_rdata       = r_rdata;
  assign mem_write_enable = (r_state == WRITE);
  assign mem_address      = ((r_state == LOAD) || (r_state == READ) || (r_state == WRITE)) ?
                            {2'b00, r_addr[ADDR_WIDTH-1:2]} : '0;
  assign mem_data_in      = (r_state != WRITE) ? '0 :
                            (r_funct3 == 3'b010) ? r_wdata : w_merged;

endmodule
